// File: rtl/interrupt_ack_sequencer_if.sv
// Bus between the 8259 acknowledge sequencer and its neighbours (IRR/mask,
// command decoder, data bus buffer). master = surrounding logic, slave = sequencer.
interface interrupt_ack_sequencer_if;
  logic [7:0] irr_masked;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       eoi_ns;
  logic       aeoi_mode;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output irr_masked, inta_n, vector_base, eoi_ns, aeoi_mode,
    input  int_out, isr, irr_clear, data_out, data_oe
  );

  modport slave (
    input  irr_masked, inta_n, vector_base, eoi_ns, aeoi_mode,
    output int_out, isr, irr_clear, data_out, data_oe
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// 8259 interrupt-acknowledge sequencer: fixed-priority resolution, ISR ownership
// and the two-pulse 8086 INTA handshake. Define AEOI_EN to build automatic EOI.
//
// state   | meaning
// S_IDLE  | no qualified request outstanding
// S_REQ   | int_out high, waiting for first INTA falling edge
// S_ACK1  | first INTA pulse low, level committed
// S_WAIT2 | between the two INTA pulses
// S_ACK2  | second INTA pulse low, vector on the bus
module interrupt_ack_sequencer #(
  parameter int NUM_IRQ        = 8,
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  interrupt_ack_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACK1,
    S_WAIT2,
    S_ACK2
  } state_t;

  state_t               state_q, state_d;
  logic                 int_q, int_d;
  logic [NUM_IRQ-1:0]   isr_q, isr_d;
  logic [NUM_IRQ-1:0]   irr_clr_q, irr_clr_d;
  logic [7:0]           dout_q, dout_d;
  logic                 oe_q, oe_d;
  logic [2:0]           level_q, level_d;
  logic                 inta_prev_q;

  logic [3:0]           win, cur;
  logic                 qualify;
  logic                 inta_fall, inta_rise;
  logic [NUM_IRQ-1:0]   set_mask, eoi_clr, aeoi_clr;

  // Index 8 on cur means "nothing in service", so any request outranks it.
  always_comb begin
    win = 4'd8;
    cur = 4'd8;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bus.irr_masked[i]) win = 4'(i);
      if (isr_q[i])          cur = 4'(i);
    end
    qualify = (bus.irr_masked != '0) && (win < cur);
  end

  assign inta_fall = inta_prev_q & ~bus.inta_n;
  assign inta_rise = ~inta_prev_q & bus.inta_n;

  always_comb begin
    eoi_clr = '0;
    if (bus.eoi_ns && !cur[3]) eoi_clr[cur[2:0]] = 1'b1;
  end

`ifdef AEOI_EN
  logic spur_q, spur_d;

  // Spurious acknowledges never set an ISR bit, so AEOI must not clear one.
  always_comb begin
    spur_d   = spur_q;
    aeoi_clr = '0;
    if (state_q == S_REQ && inta_fall) spur_d = !qualify;
    if (state_q == S_ACK2 && inta_rise && bus.aeoi_mode && !spur_q)
      aeoi_clr[level_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) spur_q <= 1'b0;
    else     spur_q <= spur_d;
  end
`else
  logic unused_aeoi_mode;
  assign unused_aeoi_mode = bus.aeoi_mode;
  assign aeoi_clr         = '0;
`endif

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    level_d  = level_q;
    set_mask = '0;
    case (state_q)
      S_IDLE: begin
        if (qualify) begin
          state_d = S_REQ;
          int_d   = 1'b1;
        end
      end
      S_REQ: begin
        // A falling edge wins over a withdrawn request: that is the spurious case.
        if (inta_fall) begin
          state_d = S_ACK1;
          int_d   = 1'b0;
          if (qualify) begin
            level_d            = win[2:0];
            set_mask[win[2:0]] = 1'b1;
          end else begin
            level_d = 3'(SPURIOUS_LEVEL);
          end
        end else if (!qualify) begin
          state_d = S_IDLE;
          int_d   = 1'b0;
        end
      end
      S_ACK1: begin
        if (inta_rise) state_d = S_WAIT2;
      end
      S_WAIT2: begin
        if (inta_fall) begin
          state_d = S_ACK2;
          dout_d  = {bus.vector_base, level_q};
          oe_d    = 1'b1;
        end
      end
      S_ACK2: begin
        if (inta_rise) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    irr_clr_d = set_mask;
    isr_d     = (isr_q & ~eoi_clr & ~aeoi_clr) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      int_q       <= 1'b0;
      isr_q       <= '0;
      irr_clr_q   <= '0;
      dout_q      <= '0;
      oe_q        <= 1'b0;
      level_q     <= '0;
      inta_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      isr_q       <= isr_d;
      irr_clr_q   <= irr_clr_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      level_q     <= level_d;
      inta_prev_q <= bus.inta_n;
    end
  end

  assign bus.int_out   = int_q;
  assign bus.isr       = isr_q;
  assign bus.irr_clear = irr_clr_q;
  assign bus.data_out  = dout_q;
  assign bus.data_oe   = oe_q;

endmodule
